// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for the 16-bit x 8 register file write port.
// Each source has a one-entry slot; the older slot wins, ties go to memory.
module regfile_write_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [2:0]  alu_addr,
  input  logic [15:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] mem_data,
  input  logic [2:0]  rs,
  input  logic [2:0]  rd,
  output logic        rs_pending,
  output logic        rd_pending,
  output logic        op_reg_write,
  output logic [2:0]  address_for_write,
  output logic [15:0] data_for_write,
  output logic        idle
);

  logic        alu_v_q, alu_v_d;
  logic [2:0]  alu_addr_q, alu_addr_d;
  logic [15:0] alu_data_q, alu_data_d;
  logic        mem_v_q, mem_v_d;
  logic [2:0]  mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        mem_older_q, mem_older_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;

  logic grant_alu, grant_mem;
  logic alu_acc, mem_acc;
  logic alu_stay, mem_stay;

  // Grant depends on slot state only, so ready never depends on the valid inputs.
  assign grant_mem = mem_v_q & (~alu_v_q | mem_older_q);
  assign grant_alu = alu_v_q & (~mem_v_q | ~mem_older_q);

  assign alu_ready = reset & (~alu_v_q | grant_alu);
  assign mem_ready = reset & (~mem_v_q | grant_mem);

  assign alu_acc  = alu_valid & alu_ready;
  assign mem_acc  = mem_valid & mem_ready;
  assign alu_stay = alu_v_q & ~grant_alu;
  assign mem_stay = mem_v_q & ~grant_mem;

  always_comb begin
    alu_v_d    = alu_stay;
    alu_addr_d = alu_addr_q;
    alu_data_d = alu_data_q;
    if (alu_acc) begin
      alu_v_d    = 1'b1;
      alu_addr_d = alu_addr;
      alu_data_d = alu_data;
    end

    mem_v_d    = mem_stay;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (mem_acc) begin
      mem_v_d    = 1'b1;
      mem_addr_d = mem_addr;
      mem_data_d = mem_data;
    end

    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (grant_mem) begin
      wr_en_d   = 1'b1;
      wr_addr_d = mem_addr_q;
      wr_data_d = mem_data_q;
    end else if (grant_alu) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_addr_q;
      wr_data_d = alu_data_q;
    end

    // A slot that waited is older than one just captured; same-edge captures favour the load.
    mem_older_d = mem_older_q;
    if (alu_stay && mem_acc) begin
      mem_older_d = 1'b0;
    end else if (mem_stay && alu_acc) begin
      mem_older_d = 1'b1;
    end else if (alu_acc && mem_acc) begin
      mem_older_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      alu_v_q     <= 1'b0;
      alu_addr_q  <= 3'd0;
      alu_data_q  <= 16'd0;
      mem_v_q     <= 1'b0;
      mem_addr_q  <= 3'd0;
      mem_data_q  <= 16'd0;
      mem_older_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 3'd0;
      wr_data_q   <= 16'd0;
    end else begin
      alu_v_q     <= alu_v_d;
      alu_addr_q  <= alu_addr_d;
      alu_data_q  <= alu_data_d;
      mem_v_q     <= mem_v_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_older_q <= mem_older_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign op_reg_write      = wr_en_q;
  assign address_for_write = wr_addr_q;
  assign data_for_write    = wr_data_q;

  assign rs_pending = reset & ((alu_v_q & (alu_addr_q == rs)) |
                               (mem_v_q & (mem_addr_q == rs)) |
                               (wr_en_q & (wr_addr_q == rs)));
  assign rd_pending = reset & ((alu_v_q & (alu_addr_q == rd)) |
                               (mem_v_q & (mem_addr_q == rd)) |
                               (wr_en_q & (wr_addr_q == rd)));

  assign idle = ~reset | (~alu_v_q & ~mem_v_q & ~wr_en_q);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; cycle k starts 1 time unit after a posedge.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [2:0]  alu_addr = 3'd0;
  logic [15:0] alu_data = 16'd0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [2:0]  mem_addr = 3'd0;
  logic [15:0] mem_data = 16'd0;
  logic [2:0]  rs = 3'd0;
  logic [2:0]  rd = 3'd0;
  logic        rs_pending, rd_pending;
  logic        op_reg_write;
  logic [2:0]  address_for_write;
  logic [15:0] data_for_write;
  logic        idle;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .alu_valid         (alu_valid),
    .alu_ready         (alu_ready),
    .alu_addr          (alu_addr),
    .alu_data          (alu_data),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .mem_addr          (mem_addr),
    .mem_data          (mem_data),
    .rs                (rs),
    .rd                (rd),
    .rs_pending        (rs_pending),
    .rd_pending        (rd_pending),
    .op_reg_write      (op_reg_write),
    .address_for_write (address_for_write),
    .data_for_write    (data_for_write),
    .idle              (idle)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [2:0] a, input logic [15:0] d);
    check_eq({tag, "_we"}, 32'(op_reg_write), 32'd1);
    check_eq({tag, "_addr"}, 32'(address_for_write), 32'(a));
    check_eq({tag, "_data"}, 32'(data_for_write), 32'(d));
  endtask

  // Contention expectations, hand-derived: commits M0 A0 M1 A1 M2 A2 M3 in cycles 2..8.
  logic [15:0] cont_exp [7] = '{16'hE000, 16'hA000, 16'hE001, 16'hA001,
                                16'hE002, 16'hA002, 16'hE003};
  // Readies during cycles 0..5: bit0 = mem_ready, bit1 = alu_ready.
  logic [1:0]  cont_rdy [6] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    int mi, ai;
    bit macc, aacc;

    // Power-up reset
    step();
    #1;
    check_eq("rst0_idle", 32'(idle), 32'd1);
    check_eq("rst0_alu_ready", 32'(alu_ready), 32'd0);
    check_eq("rst0_mem_ready", 32'(mem_ready), 32'd0);
    check_eq("rst0_we", 32'(op_reg_write), 32'd0);
    check_eq("rst0_addr", 32'(address_for_write), 32'd0);
    check_eq("rst0_data", 32'(data_for_write), 32'd0);
    step();
    reset = 1'b1;
    #1;
    check_eq("rel0_alu_ready", 32'(alu_ready), 32'd1);
    check_eq("rel0_mem_ready", 32'(mem_ready), 32'd1);

    // Single write
    alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'h1234; rs = 3'd3;
    step();
    alu_valid = 1'b0;
    #1;
    check_eq("sw_c1_pend", 32'(rs_pending), 32'd1);
    check_eq("sw_c1_we", 32'(op_reg_write), 32'd0);
    step();
    check_write("sw_c2", 3'd3, 16'h1234);
    check_eq("sw_c2_pend", 32'(rs_pending), 32'd1);
    step();
    check_eq("sw_c3_we", 32'(op_reg_write), 32'd0);
    check_eq("sw_c3_pend", 32'(rs_pending), 32'd0);
    rs = 3'd0;

    // Simultaneous offer
    mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 16'h5555;
    step();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    check_eq("sim_c1_alu_ready", 32'(alu_ready), 32'd0);
    check_eq("sim_c1_we", 32'(op_reg_write), 32'd0);
    step();
    check_write("sim_c2", 3'd2, 16'hAAAA);
    check_eq("sim_c2_alu_ready", 32'(alu_ready), 32'd1);
    step();
    check_write("sim_c3", 3'd5, 16'h5555);
    step();
    check_eq("sim_c4_we", 32'(op_reg_write), 32'd0);

    // ALU streaming
    for (int c = 0; c <= 10; c++) begin
      alu_valid = (c < 8);
      alu_addr  = 3'(c);
      alu_data  = 16'h0100 + 16'(c);
      #1;
      if (c < 8) check_eq($sformatf("str_c%0d_ready", c), 32'(alu_ready), 32'd1);
      if (c >= 2 && c <= 9) check_write($sformatf("str_c%0d", c), 3'(c - 2), 16'h0100 + 16'(c - 2));
      if (c == 10) check_eq("str_c10_we", 32'(op_reg_write), 32'd0);
      step();
    end
    alu_valid = 1'b0;

    // Contention ordering, all to r4
    mi = 0; ai = 0;
    mem_addr = 3'd4; alu_addr = 3'd4;
    for (int c = 0; c <= 9; c++) begin
      mem_valid = (c < 6);
      alu_valid = (c < 6);
      mem_data  = 16'hE000 + 16'(mi);
      alu_data  = 16'hA000 + 16'(ai);
      #1;
      if (c < 6) begin
        check_eq($sformatf("con_c%0d_mem_ready", c), 32'(mem_ready), 32'(cont_rdy[c][0]));
        check_eq($sformatf("con_c%0d_alu_ready", c), 32'(alu_ready), 32'(cont_rdy[c][1]));
      end
      if (c >= 2 && c <= 8) check_write($sformatf("con_c%0d", c), 3'd4, cont_exp[c - 2]);
      if (c == 9) begin
        check_eq("con_c9_we", 32'(op_reg_write), 32'd0);
        check_eq("con_final_r4", 32'(data_for_write), 32'h0000E003);
      end
      macc = mem_valid & mem_ready;
      aacc = alu_valid & alu_ready;
      step();
      if (macc) mi++;
      if (aacc) ai++;
    end
    mem_valid = 1'b0; alu_valid = 1'b0;

    // Hazard flag
    rd = 3'd6; rs = 3'd1;
    mem_valid = 1'b1; mem_addr = 3'd6; mem_data = 16'hBEEF;
    #1;
    check_eq("hz_c0_rd_pend", 32'(rd_pending), 32'd0);
    step();
    mem_valid = 1'b0;
    #1;
    check_eq("hz_c1_rd_pend", 32'(rd_pending), 32'd1);
    check_eq("hz_c1_rs_pend", 32'(rs_pending), 32'd0);
    step();
    check_write("hz_c2", 3'd6, 16'hBEEF);
    check_eq("hz_c2_rd_pend", 32'(rd_pending), 32'd1);
    check_eq("hz_c2_rs_pend", 32'(rs_pending), 32'd0);
    step();
    check_eq("hz_c3_rd_pend", 32'(rd_pending), 32'd0);
    check_eq("hz_c3_idle", 32'(idle), 32'd1);

    // Reset drops both filled slots
    rd = 3'd7; rs = 3'd1;
    alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_addr = 3'd7; mem_data = 16'h7777;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("rs_c1_alu_ready", 32'(alu_ready), 32'd0);
    check_eq("rs_c1_mem_ready", 32'(mem_ready), 32'd0);
    check_eq("rs_c1_idle", 32'(idle), 32'd1);
    check_eq("rs_c1_rd_pend", 32'(rd_pending), 32'd0);
    check_eq("rs_c1_rs_pend", 32'(rs_pending), 32'd0);
    check_eq("rs_c1_we", 32'(op_reg_write), 32'd0);
    step();
    reset = 1'b1;
    #1;
    check_eq("rs_c2_alu_ready", 32'(alu_ready), 32'd1);
    check_eq("rs_c2_mem_ready", 32'(mem_ready), 32'd1);
    check_eq("rs_c2_addr", 32'(address_for_write), 32'd0);
    check_eq("rs_c2_data", 32'(data_for_write), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      check_eq($sformatf("rs_c%0d_we", c), 32'(op_reg_write), 32'd0);
      check_eq($sformatf("rs_c%0d_idle", c), 32'(idle), 32'd1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
